// File: rtl/inv_cipher_pkg.sv
// inv_cipher_pkg -- shared types, constants and GF(2^8) helpers for the
// iterative AES-128 inverse cipher.
//   blk_t  : 4x4 byte matrix, element [c][r] is byte 4c+r (byte 0 is MSB)
//   word_t : one column / key word, element [r]
//   st_e   : FSM states of inv_cipher_iter
package inv_cipher_pkg;

  typedef logic [0:3][0:3][7:0] blk_t;
  typedef logic [0:3][7:0]      word_t;

  typedef enum logic [2:0] {IDLE, EXPAND, INIT, ROUND, FINAL, DONE} st_e;

  localparam int NR = 10;
  localparam int NK = 4;

  // Round constants, 1-based.
  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Multiply by x modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box needs).
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r;
  endfunction

  // S-box computed as inverse followed by the affine transform, so no table.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

endpackage

// File: rtl/inv_cipher_iter_round.sv
// inv_round -- one combinational inverse-cipher round.
//   state_i    : current state matrix
//   rk_i       : round key for this round
//   is_final_i : 1 skips InvMixColumns (last round)
//   state_o    : InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state_i))))
module inv_round
  import inv_cipher_pkg::*;
(
  input  blk_t state_i,
  input  blk_t rk_i,
  input  logic is_final_i,
  output blk_t state_o
);

  blk_t isb;
  blk_t ark;

  always_comb begin
    isb = '0;
    // Row r rotates right by r columns.
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        isb[c][r] = inv_sbox(state_i[(c - r + 4) % 4][r]);
    ark     = isb ^ rk_i;
    state_o = ark;
    if (!is_final_i) begin
      for (int c = 0; c < 4; c++) begin
        state_o[c][0] = gmul(ark[c][0], 8'h0e) ^ gmul(ark[c][1], 8'h0b) ^
                        gmul(ark[c][2], 8'h0d) ^ gmul(ark[c][3], 8'h09);
        state_o[c][1] = gmul(ark[c][0], 8'h09) ^ gmul(ark[c][1], 8'h0e) ^
                        gmul(ark[c][2], 8'h0b) ^ gmul(ark[c][3], 8'h0d);
        state_o[c][2] = gmul(ark[c][0], 8'h0d) ^ gmul(ark[c][1], 8'h09) ^
                        gmul(ark[c][2], 8'h0e) ^ gmul(ark[c][3], 8'h0b);
        state_o[c][3] = gmul(ark[c][0], 8'h0b) ^ gmul(ark[c][1], 8'h0d) ^
                        gmul(ark[c][2], 8'h09) ^ gmul(ark[c][3], 8'h0e);
      end
    end
  end

endmodule

// File: rtl/inv_cipher_iter.sv
// inv_cipher_iter -- iterative AES-128 decryption, one FSM step per clock.
//   clk, rst (async, active-high)
//   key, data, in_valid / in_ready   : input handshake (accept only in IDLE)
//   o, out_valid / out_ready         : output handshake (held in DONE)
// The key is expanded forward to rk10 (EXPAND), then walked backwards one
// round key per ROUND cycle, so only a single round-key register exists.
// Optional macro INV_CIPHER_KEY_CACHE_EN: remembers the last key and its rk10
// so a repeated key skips EXPAND.
module inv_cipher_iter
  import inv_cipher_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  blk_t key,
  input  blk_t data,
  input  logic in_valid,
  output logic in_ready,
  output blk_t o,
  output logic out_valid,
  input  logic out_ready
);

  st_e        fsm_q, fsm_d;
  logic [3:0] cnt_q, cnt_d;
  blk_t       blk_q, blk_d;
  blk_t       rk_q, rk_d;
  blk_t       o_q, o_d;
`ifdef INV_CIPHER_KEY_CACHE_EN
  blk_t       ck_key_q, ck_key_d;
  blk_t       ck_rk_q, ck_rk_d;
  logic       ck_vld_q, ck_vld_d;
`endif

  // Key-schedule step shared by both directions: SubWord(RotWord(w)) ^ rcon,
  // where w is the last word of the forward key or the recovered last word
  // of the previous (inverse) key.
  word_t      src, t, iw1, iw2, iw3, fw0, fw1, fw2, fw3;
  logic [7:0] rc;
  blk_t       fwd_k, inv_k, rnd_out;
  logic       is_final;

  always_comb begin
    iw3   = rk_q[3] ^ rk_q[2];
    iw2   = rk_q[2] ^ rk_q[1];
    iw1   = rk_q[1] ^ rk_q[0];
    src   = (fsm_q == EXPAND) ? rk_q[3] : iw3;
    rc    = (fsm_q == EXPAND) ? rcon(cnt_q) : rcon(cnt_q + 4'd1);
    t     = {sbox(src[1]) ^ rc, sbox(src[2]), sbox(src[3]), sbox(src[0])};
    fw0   = rk_q[0] ^ t;
    fw1   = rk_q[1] ^ fw0;
    fw2   = rk_q[2] ^ fw1;
    fw3   = rk_q[3] ^ fw2;
    fwd_k = {fw0, fw1, fw2, fw3};
    inv_k = {rk_q[0] ^ t, iw1, iw2, iw3};
  end

  assign is_final = (fsm_q == FINAL);

  inv_round u_round (
    .state_i    (blk_q),
    .rk_i       (inv_k),
    .is_final_i (is_final),
    .state_o    (rnd_out)
  );

  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    blk_d = blk_q;
    rk_d  = rk_q;
    o_d   = o_q;
`ifdef INV_CIPHER_KEY_CACHE_EN
    ck_key_d = ck_key_q;
    ck_rk_d  = ck_rk_q;
    ck_vld_d = ck_vld_q;
`endif
    case (fsm_q)
      IDLE: if (in_valid) begin
        blk_d = data;
        rk_d  = key;
        cnt_d = 4'd1;
        fsm_d = EXPAND;
`ifdef INV_CIPHER_KEY_CACHE_EN
        if (ck_vld_q && key == ck_key_q) begin
          rk_d  = ck_rk_q;
          fsm_d = INIT;
        end else begin
          // Cache becomes valid only once rk10 is actually produced.
          ck_key_d = key;
          ck_vld_d = 1'b0;
        end
`endif
      end
      EXPAND: begin
        rk_d = fwd_k;
        if (cnt_q == 4'(NR)) begin
          fsm_d = INIT;
`ifdef INV_CIPHER_KEY_CACHE_EN
          ck_rk_d  = fwd_k;
          ck_vld_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      INIT: begin
        blk_d = blk_q ^ rk_q;
        cnt_d = 4'(NR - 1);
        fsm_d = ROUND;
      end
      ROUND: begin
        blk_d = rnd_out;
        rk_d  = inv_k;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) fsm_d = FINAL;
      end
      FINAL: begin
        o_d   = rnd_out;
        fsm_d = DONE;
      end
      DONE: if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= IDLE;
      cnt_q <= '0;
      blk_q <= '0;
      rk_q  <= '0;
      o_q   <= '0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      blk_q <= blk_d;
      rk_q  <= rk_d;
      o_q   <= o_d;
    end
  end

`ifdef INV_CIPHER_KEY_CACHE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ck_key_q <= '0;
      ck_rk_q  <= '0;
      ck_vld_q <= 1'b0;
    end else begin
      ck_key_q <= ck_key_d;
      ck_rk_q  <= ck_rk_d;
      ck_vld_q <= ck_vld_d;
    end
  end
`endif

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign o         = o_q;

endmodule

// File: tb/tb_inv_cipher_iter.sv
module tb_inv_cipher_iter;
  import inv_cipher_pkg::*;

  localparam logic [127:0] C1_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_C  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_P  = 128'h3243f6a8885a308d313198a2e0370734;
`ifdef INV_CIPHER_KEY_CACHE_EN
  localparam int HIT_LAT = 11;
`else
  localparam int HIT_LAT = 21;
`endif

  logic clk, rst, in_valid, in_ready, out_valid, out_ready;
  blk_t key, data, o;

  inv_cipher_iter dut (
    .clk(clk), .rst(rst), .key(key), .data(data), .in_valid(in_valid),
    .in_ready(in_ready), .o(o), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [127:0] pt; int lat; int acc; } exp_t;
  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  logic pv    = 1'b0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Monitor: compare plaintext and latency on each rising out_valid.
  always @(negedge clk) begin
    if (!rst && out_valid && !pv) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out got=%h exp=none", o);
      end else begin
        e = sb.pop_front();
        chk("plaintext", o, e.pt);
        chk("latency", 128'(cyc - e.acc), 128'(e.lat));
      end
    end
    pv = rst ? 1'b0 : out_valid;
  end

  task automatic send(input logic [127:0] k, input logic [127:0] d,
                      input logic [127:0] p, input int lat);
    int n = 0;
    @(negedge clk);
    key = k; data = d; in_valid = 1'b1;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout got=busy exp=ready");
      in_valid = 1'b0;
      return;
    end
    sb.push_back('{p, lat, cyc + 1});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(sb.size() == 0 && in_ready && !out_valid) && n < 60) begin
      @(negedge clk); n++;
    end
    if (n >= 60) begin
      total++; bad++;
      $display("FAIL idle_timeout got=busy exp=idle");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; key = '0; data = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_o", o, 128'd0);
    rst = 1'b0;

    // Known-answer vectors; first accept right after reset release.
    send(C1_K, C1_C, C1_P, 21);
    wait_idle();
    send(B_K, B_C, B_P, 21);
    wait_idle();

    // Backpressure: output must hold while out_ready is low.
    out_ready = 1'b0;
    send(C1_K, C1_C, C1_P, 21);
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_o", o, C1_P);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 128'(out_valid), 128'd0);
    chk("bp_release_ready", 128'(in_ready), 128'd1);
    wait_idle();

    // Reset mid-run aborts the operation and clears o at once.
    send(B_K, B_C, B_P, 21);
    repeat (12) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_o", o, 128'd0);
    chk("midrst_in_ready", 128'(in_ready), 128'd1);
    if (sb.size() > 0) void'(sb.pop_back());
    @(negedge clk) rst = 1'b0;
    send(C1_K, C1_C, C1_P, 21);
    wait_idle();

    // Repeated key (cache hit when enabled), then a new key.
    send(C1_K, C1_C, C1_P, HIT_LAT);
    wait_idle();
    send(B_K, B_C, B_P, 21);
    wait_idle();

    // in_valid pulsed while busy is ignored.
    send(C1_K, C1_C, C1_P, 21);
    repeat (13) @(negedge clk);
    key = B_K; data = B_C; in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("sb_drained", 128'(sb.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inv_cipher_iter.md
INV_CIPHER_ITER -- requirements
Module: inv_cipher_iter

Interface
- REQ-001 Parameters SHALL be none: AES-128 only, Nk = 4 and Nr = 10 fixed by package constants.
- REQ-002 `clk`  in  1  rising-edge clock.
- REQ-003 `rst`  in  1  reset; asynchronous and active-high, as already decided.
- REQ-004 `key`  in  [7:0] x [0:3][0:3]  cipher key; element [c][r] is FIPS-197 byte 4c+r.
- REQ-005 `data`  in  [7:0] x [0:3][0:3]  ciphertext block, same layout as `key`.
- REQ-006 `in_valid`  in  1  `key` and `data` are valid.
- REQ-007 `in_ready`  out  1  block can accept a new input.
- REQ-008 `o`  out  [7:0] x [0:3][0:3]  plaintext block, same layout as `key`.
- REQ-009 `out_valid`  out  1  `o` holds a completed plaintext.
- REQ-010 `out_ready`  in  1  consumer accepts `o`.

Function
- REQ-011 The block SHALL implement the FIPS-197 InvCipher iteratively, with one state-machine step per `clk` cycle.
- REQ-012 The state machine SHALL have states IDLE, EXPAND, INIT, ROUND, FINAL and DONE.
- REQ-013 `in_ready` SHALL be 1 only in IDLE.
- REQ-014 An input is accepted when `in_valid` and `in_ready` are both 1 on a rising edge; the block SHALL then latch `key` and `data` and go to EXPAND.
- REQ-015 EXPAND SHALL last 10 cycles and produce forward round keys rk1..rk10; only the current round key register is kept, not all 11 keys.
- REQ-016 INIT SHALL last 1 cycle and set state = data XOR rk10.
- REQ-017 ROUND SHALL last 9 cycles for r = 9 down to 1.
- REQ-018 Each ROUND cycle SHALL apply InvShiftRows, then InvSubBytes, then AddRoundKey(rk_r), then InvMixColumns.
- REQ-019 Each ROUND cycle SHALL derive rk_r from rk_(r+1) by the inverse key schedule in the same cycle, using rcon[r+1] (1-based) and the S-box.
- REQ-020 FINAL SHALL last 1 cycle: InvShiftRows, InvSubBytes, AddRoundKey(rk0); it loads `o` and sets `out_valid` = 1.
- REQ-021 The latency from the accept edge to `out_valid` = 1 SHALL be 21 cycles.
- REQ-022 DONE SHALL hold `o` and `out_valid` = 1 stable until `out_ready` = 1 on an edge.
- REQ-023 On that edge `out_valid` SHALL fall to 0 and the state SHALL return to IDLE.
- REQ-024 `o` SHALL keep its last value after DONE.
- REQ-025 There SHALL be no same-cycle DONE-to-accept bypass; the next accept occurs at the earliest one cycle after DONE exits.
- REQ-026 `in_valid` outside IDLE SHALL be ignored, with no side effects.
- REQ-027 `out_ready` outside DONE SHALL be ignored.
- REQ-028 All GF(2^8) arithmetic SHALL use modulus 0x11B; all byte operations are 8-bit modulo.

Reset
- REQ-029 Asserting `rst` SHALL, asynchronously: go to IDLE, set `in_ready` = 1, `out_valid` = 0, `o` = all zeros, and clear the state and round-key registers.
- REQ-030 Reset during EXPAND, ROUND or DONE SHALL abort the operation; no partial result is ever presented.
- REQ-031 The first accept after reset release SHALL be possible on the first rising edge with `rst` = 0.

Configuration
- REQ-032 The optional feature SHALL be controlled by the macro INV_CIPHER_KEY_CACHE_EN.
- REQ-033 When defined, the block SHALL store the last expanded `key` and its rk10, with a cache-valid flag that `rst` clears.
- REQ-034 When defined, an accepted `key` equal to the cached key with the flag set SHALL skip EXPAND (IDLE→INIT), giving a latency of 11 cycles.
- REQ-035 When not defined, no cache registers SHALL exist and the latency SHALL always be 21 cycles.

Structure
- REQ-036 The shared package inv_cipher_pkg SHALL hold:
  - the byte-matrix typedef [7:0] x [0:3][0:3];
  - constants NR = 10 and NK = 4 and the rcon table;
  - sbox, inv_sbox, xtime and gmul functions.
- REQ-037 The pure-combinational sub-module inv_round SHALL take (state, round key, is_final) and return the next state.
- REQ-038 The FSM, the counters and the key-schedule step SHALL live in inv_cipher_iter.

Verification
- REQ-039 FIPS-197 C.1:
  - stimulus: key 000102030405060708090a0b0c0d0e0f, data 69c4e0d86a7b0430d8cdb78070b4c55a;
  - response: o = 00112233445566778899aabbccddeeff and out_valid at cycle 21.
- REQ-040 FIPS-197 Appendix B:
  - stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, data 3925841d02dc09fbdc118597196a0b32;
  - response: o = 3243f6a8885a308d313198a2e0370734.
- REQ-041 Backpressure: hold out_ready = 0 for 5 cycles after out_valid → o and out_valid stay stable and in_ready = 0; then out_ready = 1 → in_ready = 1 the next cycle.
- REQ-042 Reset mid-run: assert rst at cycle 12 after an accept → out_valid = 0 and o = 0 immediately; the next C.1 vector then decrypts correctly.
- REQ-043 With INV_CIPHER_KEY_CACHE_EN defined: C.1 twice back-to-back → latency 21 then 11; a different key → 21 again.
- REQ-044 Pulsing in_valid during ROUND with other data → the result still equals the first vector's plaintext.
